// File: rtl/rans_encoder.sv
// Streaming rANS encoder: per-symbol freq/cumul table, renormalisation chunk output,
// serial restoring divider for x/f and x%f, and a flush that emits the final state LSB-first.
module rans_encoder #(
  parameter int SYMBOL_WIDTH = 4,
  parameter int LOG_M        = 10,
  parameter int STATE_WIDTH  = 32,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    config_en,
  input  logic [SYMBOL_WIDTH-1:0] config_symbol,
  input  logic [LOG_M-1:0]        config_freq,
  input  logic [LOG_M-1:0]        config_cumul,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [SYMBOL_WIDTH-1:0] sym_in,
  input  logic                    flush_valid,
  output logic                    flush_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic [STATE_WIDTH-1:0]  state_out,
  output logic                    err_zero_freq
);

  localparam int DEPTH  = 1 << SYMBOL_WIDTH;
  localparam int NCHUNK = STATE_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = $clog2(STATE_WIDTH) + 1;
  localparam logic [STATE_WIDTH-1:0] L_INIT = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RENORM,
    S_DIVIDE,
    S_UPDATE,
    S_FLUSH
  } fsm_t;

  fsm_t                    fsm_q;
  logic [STATE_WIDTH-1:0]  state_q;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic [LOG_M-1:0]        f_q;
  logic [LOG_M-1:0]        c_q;
  logic [STATE_WIDTH-1:0]  dvd_q;   // dividend/quotient while dividing, state shifter while flushing
  logic [LOG_M:0]          rem_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    out_valid_q;
  logic [OUT_WIDTH-1:0]    out_data_q;
  logic                    out_last_q;
  logic                    err_q;
  logic [LOG_M-1:0]        freq_q  [DEPTH];
  logic [LOG_M-1:0]        cumul_q [DEPTH];

  logic [STATE_WIDTH:0]    x_max_d;
  logic [STATE_WIDTH-1:0]  x_shr_d;
  logic                    x_hit_d;
  logic                    shr_hit_d;
  logic [LOG_M:0]          rem_shift_d;
  logic                    q_bit_d;
  logic [LOG_M:0]          rem_d;
  logic [STATE_WIDTH-1:0]  x_upd_d;
  logic [STATE_WIDTH-1:0]  flush_shr_d;

  // NOTE: every signal written in always_comb gets a value on every path, so no latches are inferred.
  always_comb begin
    x_max_d     = {1'b0, f_q, {(STATE_WIDTH-LOG_M){1'b0}}};
    x_shr_d     = state_q >> OUT_WIDTH;
    x_hit_d     = {1'b0, state_q} >= x_max_d;
    shr_hit_d   = {1'b0, x_shr_d} >= x_max_d;
    rem_shift_d = {rem_q[LOG_M-1:0], dvd_q[STATE_WIDTH-1]};
    q_bit_d     = rem_shift_d >= {1'b0, f_q};
    rem_d       = q_bit_d ? (rem_shift_d - {1'b0, f_q}) : rem_shift_d;
    x_upd_d     = (dvd_q << LOG_M)
                + {{(STATE_WIDTH-LOG_M-1){1'b0}}, rem_q}
                + {{(STATE_WIDTH-LOG_M){1'b0}}, c_q};
    flush_shr_d = dvd_q >> OUT_WIDTH;
  end

  assign sym_ready     = (fsm_q == S_IDLE) && !config_en;
  assign flush_ready   = (fsm_q == S_IDLE) && !config_en && !sym_valid;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign state_out     = state_q;
  assign err_zero_freq = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_q     <= L_INIT;
      sym_q       <= '0;
      f_q         <= '0;
      c_q         <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the table is reset to all-zero because an unconfigured symbol must read as freq 0.
      for (int i = 0; i < DEPTH; i++) begin
        freq_q[i]  <= '0;
        cumul_q[i] <= '0;
      end
    end else if (config_en) begin
      freq_q[config_symbol]  <= config_freq;
      cumul_q[config_symbol] <= config_cumul;
      fsm_q       <= S_IDLE;
      state_q     <= L_INIT;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (sym_valid && sym_ready) begin
            sym_q <= sym_in;
            fsm_q <= S_LOOKUP;
          end else if (flush_valid && flush_ready) begin
            dvd_q       <= state_q;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= state_q[OUT_WIDTH-1:0];
            out_last_q  <= (NCHUNK == 1);
            fsm_q       <= S_FLUSH;
          end
        end

        S_LOOKUP: begin
          f_q <= freq_q[sym_q];
          c_q <= cumul_q[sym_q];
          if (freq_q[sym_q] == '0) begin
            err_q <= 1'b1;
            fsm_q <= S_IDLE;
          end else begin
            fsm_q <= S_RENORM;
          end
        end

        // A chunk's handshake re-compares the shifted state in the same cycle, so each chunk costs one cycle.
        S_RENORM: begin
          if (out_valid_q) begin
            if (out_ready) begin
              state_q <= x_shr_d;
              if (shr_hit_d) begin
                out_data_q <= x_shr_d[OUT_WIDTH-1:0];
              end else begin
                out_valid_q <= 1'b0;
                dvd_q       <= x_shr_d;
                rem_q       <= '0;
                cnt_q       <= '0;
                fsm_q       <= S_DIVIDE;
              end
            end
          end else if (x_hit_d) begin
            out_valid_q <= 1'b1;
            out_data_q  <= state_q[OUT_WIDTH-1:0];
            out_last_q  <= 1'b0;
          end else begin
            dvd_q <= state_q;
            rem_q <= '0;
            cnt_q <= '0;
            fsm_q <= S_DIVIDE;
          end
        end

        S_DIVIDE: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[STATE_WIDTH-2:0], q_bit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STATE_WIDTH - 1)) fsm_q <= S_UPDATE;
        end

        S_UPDATE: begin
          state_q <= x_upd_d;
          fsm_q   <= S_IDLE;
        end

        S_FLUSH: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= L_INIT;
              fsm_q       <= S_IDLE;
            end else begin
              dvd_q      <= flush_shr_d;
              out_data_q <= flush_shr_d[OUT_WIDTH-1:0];
              cnt_q      <= cnt_q + 1'b1;
              out_last_q <= (cnt_q == CNT_W'(NCHUNK - 2));
            end
          end
        end

        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_encoder.sv
// Self-checking bench for rans_encoder: directed test-plan cases plus randomized symbol/flush
// streams checked against an arithmetic rANS model and a chunk scoreboard.
module tb_rans_encoder;

  localparam int SYMBOL_WIDTH = 4;
  localparam int LOG_M        = 10;
  localparam int STATE_WIDTH  = 32;
  localparam int OUT_WIDTH    = 8;
  localparam int NSYM         = 1 << SYMBOL_WIDTH;
  localparam int NCHUNK       = STATE_WIDTH / OUT_WIDTH;
  localparam int MEM_N        = 4096;
  localparam longint unsigned L_VAL  = 64'd1 << (STATE_WIDTH - OUT_WIDTH);
  localparam longint unsigned S_MASK = (64'd1 << STATE_WIDTH) - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    config_en;
  logic [SYMBOL_WIDTH-1:0] config_symbol;
  logic [LOG_M-1:0]        config_freq;
  logic [LOG_M-1:0]        config_cumul;
  logic                    sym_valid;
  logic                    sym_ready;
  logic [SYMBOL_WIDTH-1:0] sym_in;
  logic                    flush_valid;
  logic                    flush_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_last;
  logic [STATE_WIDTH-1:0]  state_out;
  logic                    err_zero_freq;

  rans_encoder #(
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .LOG_M       (LOG_M),
    .STATE_WIDTH (STATE_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .config_en    (config_en),
    .config_symbol(config_symbol),
    .config_freq  (config_freq),
    .config_cumul (config_cumul),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym_in       (sym_in),
    .flush_valid  (flush_valid),
    .flush_ready  (flush_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .state_out    (state_out),
    .err_zero_freq(err_zero_freq)
  );

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
  } chunk_t;

  chunk_t exp_mem [MEM_N];
  chunk_t rx_mem  [MEM_N];
  int     exp_wr = 0;
  int     exp_rd = 0;
  int     rx_n   = 0;
  int     n_vec  = 0;
  int     n_err  = 0;
  int     rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  int unsigned     m_freq  [NSYM];
  int unsigned     m_cumul [NSYM];
  longint unsigned m_x;
  bit              m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic push_exp(input longint unsigned d, input bit last);
    if (exp_wr < MEM_N) begin
      exp_mem[exp_wr] = '{data: OUT_WIDTH'(d), last: last};
      exp_wr++;
    end
  endtask

  task automatic model_reset_state();
    m_x   = L_VAL;
    m_err = 1'b0;
  endtask

  task automatic model_sym(input int s);
    longint unsigned x = m_x;
    longint unsigned f = m_freq[s];
    longint unsigned c = m_cumul[s];
    if (f == 0) begin
      m_err = 1'b1;
      return;
    end
    while (x >= (f << (STATE_WIDTH - LOG_M))) begin
      push_exp(x & ((64'd1 << OUT_WIDTH) - 1), 1'b0);
      x = x >> OUT_WIDTH;
    end
    m_x = (((x / f) << LOG_M) + (x % f) + c) & S_MASK;
  endtask

  task automatic model_flush();
    for (int i = 0; i < NCHUNK; i++)
      push_exp((m_x >> (i * OUT_WIDTH)) & ((64'd1 << OUT_WIDTH) - 1), i == NCHUNK - 1);
    m_x = L_VAL;
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- chunk compare process ----------------
  initial begin : cmp
    logic                 stall_q;
    logic [OUT_WIDTH-1:0] stall_data;
    logic                 stall_last;
    stall_q    = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !config_en) begin
        if (stall_q) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, stall_data);
          check("stall_last", out_last, stall_last);
        end
        if (out_valid && out_ready) begin
          if (rx_n < MEM_N) begin
            rx_mem[rx_n] = '{data: out_data, last: out_last};
            rx_n++;
          end
          check("chunk_expected", exp_wr > exp_rd, 1);
          if (exp_wr > exp_rd) begin
            check("chunk_data", out_data, exp_mem[exp_rd].data);
            check("chunk_last", out_last, exp_mem[exp_rd].last);
            exp_rd++;
          end
        end
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic config_sym(input int s, input int unsigned f, input int unsigned c);
    config_en     = 1'b1;
    config_symbol = SYMBOL_WIDTH'(s);
    config_freq   = LOG_M'(f);
    config_cumul  = LOG_M'(c);
    @(posedge clk);
    #1 config_en = 1'b0;
    m_freq[s]  = f;
    m_cumul[s] = c;
    model_reset_state();
  endtask

  task automatic send_sym(input int s);
    bit ok = 1'b0;
    sym_in    = SYMBOL_WIDTH'(s);
    sym_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("sym_accept_wait", ok, 1);
    @(posedge clk);
    #1 sym_valid = 1'b0;
    model_sym(s);
  endtask

  task automatic send_flush();
    bit ok = 1'b0;
    flush_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (flush_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("flush_accept_wait", ok, 1);
    @(posedge clk);
    #1 flush_valid = 1'b0;
    model_flush();
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle_wait"}, ok, 1);
    check({name, "_state"}, state_out, m_x);
    check({name, "_err"}, err_zero_freq, m_err);
    check({name, "_chunks_drained"}, exp_rd, exp_wr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, state_out, L_VAL);
    check({name, "_sym_ready"}, sym_ready, 1);
    check({name, "_flush_ready"}, flush_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_out_last"}, out_last, 0);
    check({name, "_err"}, err_zero_freq, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] flush_lit [NCHUNK];
    int base;
    int unsigned fr [NSYM];
    int unsigned sum;
    int unsigned cum;

    flush_lit[0] = 8'h00;
    flush_lit[1] = 8'h02;
    flush_lit[2] = 8'h00;
    flush_lit[3] = 8'h08;

    rst_n = 1'b0;
    config_en = 1'b0;
    config_symbol = '0;
    config_freq = '0;
    config_cumul = '0;
    sym_valid = 1'b0;
    sym_in = '0;
    flush_valid = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      m_freq[i]  = 0;
      m_cumul[i] = 0;
    end
    model_reset_state();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-symbol sequence with exact latency on the first symbol.
    config_sym(0, 512, 0);
    config_sym(1, 256, 512);
    send_sym(0);
    repeat (34) @(posedge clk);
    #1 check("lat_hold_state", state_out, 32'h0100_0000);
    @(posedge clk);
    #1;
    check("lat_update_state", state_out, 32'h0200_0000);
    check("lat_ready_again", sym_ready, 1);
    wait_idle("sym0");
    send_sym(1);
    wait_idle("sym1");
    check("sym1_literal", state_out, 32'h0800_0200);

    // Flush of 0x0800_0200.
    base = rx_n;
    send_flush();
    wait_idle("flush");
    check("flush_count", rx_n - base, NCHUNK);
    for (int i = 0; i < NCHUNK; i++) begin
      check("flush_lit_data", rx_mem[base + i].data, flush_lit[i]);
      check("flush_lit_last", rx_mem[base + i].last, i == NCHUNK - 1);
    end
    check("flush_final_state", state_out, 32'h0100_0000);

    // Single renorm chunk with f=1.
    config_sym(2, 1, 1023);
    base = rx_n;
    send_sym(2);
    wait_idle("sym2");
    check("sym2_chunk_count", rx_n - base, 1);
    check("sym2_chunk_data", rx_mem[base].data, 8'h00);
    check("sym2_literal", state_out, 32'h0400_03FF);

    // Same symbol with out_ready held low during renorm.
    config_sym(2, 1, 1023);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_sym(2);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("stall_chunk_seen", seen, 1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_hold_valid", out_valid, 1);
      check("stall_hold_data", out_data, 8'h00);
      check("stall_hold_state", state_out, 32'h0100_0000);
    end
    rdy_mode = 0;
    wait_idle("stall");
    check("stall_literal", state_out, 32'h0400_03FF);

    // Zero-frequency symbol: sticky error, state unchanged.
    config_sym(3, 0, 0);
    send_sym(3);
    check("zf_busy", sym_ready, 0);
    @(posedge clk);
    #1;
    check("zf_ready_back", sym_ready, 1);
    check("zf_err_set", err_zero_freq, 1);
    check("zf_state_kept", state_out, 32'h0100_0000);
    wait_idle("zf");
    send_sym(0);
    wait_idle("zf_sticky");
    config_sym(3, 0, 0);
    check("zf_err_cleared", err_zero_freq, 0);

    // Symbol and flush offered together: the symbol wins.
    sym_in      = '0;
    sym_valid   = 1'b1;
    flush_valid = 1'b1;
    @(negedge clk);
    check("both_flush_ready", flush_ready, 0);
    check("both_sym_ready", sym_ready, 1);
    @(posedge clk);
    #1;
    sym_valid   = 1'b0;
    flush_valid = 1'b0;
    model_sym(0);
    check("both_busy", sym_ready, 0);
    wait_idle("both");

    // Reset asserted while dividing.
    send_sym(0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NSYM; i++) begin
      m_freq[i]  = 0;
      m_cumul[i] = 0;
    end
    model_reset_state();
    exp_wr = exp_rd;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized legal tables, random symbol/flush stream, random back-pressure.
    for (int round = 0; round < 3; round++) begin
      sum = 0;
      for (int i = 0; i < NSYM - 1; i++) begin
        fr[i] = $urandom_range(1, 63);
        sum  += fr[i];
      end
      fr[NSYM-1] = (1 << LOG_M) - sum;
      cum = 0;
      for (int i = 0; i < NSYM; i++) begin
        config_sym(i, fr[i], cum);
        cum += fr[i];
      end
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        if ($urandom_range(0, 9) == 0) send_flush();
        else send_sym($urandom_range(0, NSYM - 1));
        wait_idle("rand");
      end
      send_flush();
      wait_idle("rand_flush");
      rdy_mode = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
